// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared constants and types for the nibble-serial ALU
//               sequencer: data width, nibble count, NZVC flag indices and
//               FSM state encoding. Width is selected by ALU_SEQ_WIDE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

`ifdef ALU_SEQ_WIDE_EN
    localparam int unsigned c_WIDTH   = 16;
`else
    localparam int unsigned c_WIDTH   = 8;
`endif
    localparam int unsigned c_NIBBLES = c_WIDTH / 4;
    // Nibble index width; never below one bit
    localparam int unsigned c_K_W     = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;

    // Flag bit positions inside the 4-bit NZVC vector
    localparam int unsigned c_FLAG_N  = 3;
    localparam int unsigned c_FLAG_Z  = 2;
    localparam int unsigned c_FLAG_V  = 1;
    localparam int unsigned c_FLAG_C  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_nibble_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_seq_if
// Description : Bundle of request/response signals and the 4-bit ALU drive
//               and return signals for alu_nibble_seq. The slave modport is
//               the sequencer; the master modport is the requester plus ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_nibble_seq_if;
    // Request side
    logic                            start;
    logic [2:0]                      op;
    logic                            bank;
    logic                            cin;
    logic [alu_seq_pkg::c_WIDTH-1:0] a;
    logic [alu_seq_pkg::c_WIDTH-1:0] b;
    // Response side
    logic [alu_seq_pkg::c_WIDTH-1:0] result;
    logic                            busy;
    logic                            done;
    logic [3:0]                      flags;
    // 4-bit ALU drive
    logic [3:0]                      alu_a;
    logic [3:0]                      alu_b;
    logic [2:0]                      alu_op;
    logic                            alu_cin;
    logic                            alu_bank;
    logic                            alu_enable;
    // 4-bit ALU return (combinational)
    logic [3:0]                      alu_result;
    logic [3:0]                      alu_flags;

    modport slave (
        input  start, op, bank, cin, a, b, alu_result, alu_flags,
        output result, busy, done, flags,
               alu_a, alu_b, alu_op, alu_cin, alu_bank, alu_enable
    );

    modport master (
        output start, op, bank, cin, a, b, alu_result, alu_flags,
        input  result, busy, done, flags,
               alu_a, alu_b, alu_op, alu_cin, alu_bank, alu_enable
    );
endinterface
`default_nettype wire

// File: rtl/alu_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_seq
// Description : Runs a W-bit operation through an external 4-bit ALU one
//               nibble per cycle, chaining carry between nibbles and
//               assembling the W-bit result and NZVC flags.
//               Macro ALU_SEQ_WIDE_EN selects W=16 (default W=8).
//               DONE_HOLD=0 pulses done for one cycle; 1 holds it until the
//               next accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter bit DONE_HOLD = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    alu_nibble_seq_if.slave bus
);

    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(c_NIBBLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_K_W-1:0]     r_k;
    logic [c_WIDTH-1:0]   r_a;
    logic [c_WIDTH-1:0]   r_b;
    logic [c_WIDTH-1:0]   r_result;
    logic [2:0]           r_op;
    logic                 r_bank;
    logic                 r_cin;
    logic                 r_carry;
    logic                 r_zacc;
    logic [3:0]           r_flags;

    logic                 w_accept;
    logic                 w_run;
    logic                 w_last;
    logic                 w_z_all;
    logic [c_K_W+1:0]     w_base;

    assign w_run   = (r_state == S_RUN);
    assign w_last  = (r_k == c_K_LAST);
    assign w_base  = {r_k, 2'b00};
    // Zero flag survives only if every nibble so far reported zero
    assign w_z_all = ((r_k == '0) ? 1'b1 : r_zacc) & bus.alu_flags[c_FLAG_Z];

    // State register; reset forces IDLE asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and all outputs derived from the current state
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        bus.busy       = w_run;
        bus.done       = (r_state == S_DONE);
        bus.result     = r_result;
        bus.flags      = r_flags;
        bus.alu_enable = 1'b1;
        bus.alu_a      = 4'd0;
        bus.alu_b      = 4'd0;
        bus.alu_op     = 3'd0;
        bus.alu_cin    = 1'b0;
        bus.alu_bank   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                bus.alu_enable = 1'b0;
                bus.alu_a      = r_a[w_base +: 4];
                bus.alu_b      = r_b[w_base +: 4];
                bus.alu_op     = r_op;
                bus.alu_bank   = r_bank;
                // Nibble 0 takes the caller's carry; later nibbles chain
                bus.alu_cin    = (r_k == '0) ? r_cin : r_carry;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end else if (!DONE_HOLD) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch on accept, then per-nibble capture while running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'd0;
            r_bank   <= 1'b0;
            r_cin    <= 1'b0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            r_result <= '0;
            r_flags  <= 4'd0;
        end else if (w_accept) begin
            r_k    <= '0;
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_op   <= bus.op;
            r_bank <= bus.bank;
            r_cin  <= bus.cin;
        end else if (w_run) begin
            r_result[w_base +: 4] <= bus.alu_result;
            r_carry               <= bus.alu_flags[c_FLAG_C];
            r_zacc                <= w_z_all;
            if (w_last) begin
                r_k                <= '0;
                r_flags[c_FLAG_N]  <= bus.alu_flags[c_FLAG_N];
                r_flags[c_FLAG_Z]  <= w_z_all;
                r_flags[c_FLAG_V]  <= bus.alu_flags[c_FLAG_V];
                r_flags[c_FLAG_C]  <= bus.alu_flags[c_FLAG_C];
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_nibble_seq
// Description : Self-checking bench for alu_nibble_seq. Two instances share
//               clock and reset: DONE_HOLD=0 (u_dut0) and DONE_HOLD=1
//               (u_dut1). A 4-bit ALU model (op 0 = ADD, others = XOR) feeds
//               each instance; a full-width reference model fills per-DUT
//               scoreboards when a start is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_nibble_seq;
    import alu_seq_pkg::*;

    localparam int W = c_WIDTH;
    localparam int N = c_NIBBLES;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_nibble_seq_if u_if0 ();
    alu_nibble_seq_if u_if1 ();

    alu_nibble_seq #(.DONE_HOLD(1'b0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(u_if0));
    alu_nibble_seq #(.DONE_HOLD(1'b1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(u_if1));

    int errors = 0;
    int checks = 0;
    int edges;
    logic [W+3:0] exp_v;
    logic [W+3:0] sb0 [$];
    logic [W+3:0] sb1 [$];

    // 4-bit ALU model: returns {N,Z,V,C, result}
    function automatic logic [7:0] alu4(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        s = 5'd0;
        if (op == 3'd0) begin
            s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
            r = s[3:0];
            c = s[4];
            v = (a[3] == b[3]) && (r[3] != a[3]);
        end else begin
            r = a ^ b;
            c = 1'b0;
            v = 1'b0;
        end
        return {r[3], (r == 4'd0), v, c, r};
    endfunction

    // Full-width reference: returns {N,Z,V,C, result}
    function automatic logic [W+3:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        s = '0;
        if (op == 3'd0) begin
            s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = a ^ b;
            c = 1'b0;
            v = 1'b0;
        end
        return {r[W-1], (r == '0), v, c, r};
    endfunction

    assign {u_if0.alu_flags, u_if0.alu_result} = alu4(u_if0.alu_op, u_if0.alu_a, u_if0.alu_b, u_if0.alu_cin);
    assign {u_if1.alu_flags, u_if1.alu_result} = alu4(u_if1.alu_op, u_if1.alu_a, u_if1.alu_b, u_if1.alu_cin);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request on instance 0; returns at the negedge after acceptance
    task automatic start0(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic cin);
        u_if0.a     = a;
        u_if0.b     = b;
        u_if0.op    = op;
        u_if0.cin   = cin;
        u_if0.bank  = 1'b0;
        u_if0.start = 1'b1;
        sb0.push_back(ref_op(op, a, b, cin));
        @(posedge clk);
        @(negedge clk);
        u_if0.start = 1'b0;
    endtask

    // Wait (bounded) for done on instance 0; edges counts rising edges since
    // and including the accepting edge
    task automatic wait_done0(input int edges_in, input string tag);
        int           e;
        logic [W+3:0] x;
        e = edges_in;
        while (!u_if0.done && e < 4 * N + 4) begin
            check({tag, "_busy"}, {31'd0, u_if0.busy}, 32'd1);
            @(negedge clk);
            e++;
        end
        check({tag, "_lat"}, e, N + 1);
        check({tag, "_busy_at_done"}, {31'd0, u_if0.busy}, 32'd0);
        if (sb0.size() != 0) x = sb0.pop_front();
        else x = '0;
        check({tag, "_res"}, u_if0.result, x[W-1:0]);
        check({tag, "_flags"}, u_if0.flags, x[W+3:W]);
    endtask

    initial begin
        u_if0.start = 1'b0; u_if0.op = 3'd0; u_if0.bank = 1'b0; u_if0.cin = 1'b0;
        u_if0.a = '0; u_if0.b = '0;
        u_if1.start = 1'b0; u_if1.op = 3'd0; u_if1.bank = 1'b0; u_if1.cin = 1'b0;
        u_if1.a = '0; u_if1.b = '0;

        // Reset state
        #12;
        check("rst_busy",   {31'd0, u_if0.busy}, 32'd0);
        check("rst_done",   {31'd0, u_if0.done}, 32'd0);
        check("rst_result", u_if0.result, 32'd0);
        check("rst_flags",  u_if0.flags, 32'd0);
        check("rst_en",     {31'd0, u_if0.alu_enable}, 32'd1);
        check("rst_alu_a",  u_if0.alu_a, 32'd0);

        // Start on the first edge after reset release: 0x3C + 0x05
        @(negedge clk);
        reset_n = 1'b1;
        start0(W'(16'h003C), W'(16'h0005), 3'd0, 1'b0);
        check("add_k0_en",  {31'd0, u_if0.alu_enable}, 32'd0);
        check("add_k0_a",   u_if0.alu_a, 32'hC);
        check("add_k0_b",   u_if0.alu_b, 32'h5);
        check("add_k0_cin", {31'd0, u_if0.alu_cin}, 32'd0);
        wait_done0(1, "add");
        @(negedge clk);
        check("add_done_pulse", {31'd0, u_if0.done}, 32'd0);
        check("add_idle_en",    {31'd0, u_if0.alu_enable}, 32'd1);
        check("add_res_hold",   u_if0.result, W'(16'h0041));

        // Carry chain into nibble 1
        start0(W'(16'h00FF), W'(16'h0001), 3'd0, 1'b0);
        check("cy_k0_cin", {31'd0, u_if0.alu_cin}, 32'd0);
        @(negedge clk);
        check("cy_k1_cin", {31'd0, u_if0.alu_cin}, 32'd1);
        check("cy_k1_a",   u_if0.alu_a, 32'hF);
        wait_done0(2, "cy");

        // XOR with initial carry in
        @(negedge clk);
        start0(W'(16'h00A5), W'(16'h005A), 3'd1, 1'b1);
        check("xor_k0_op",  u_if0.alu_op, 32'd1);
        check("xor_k0_cin", {31'd0, u_if0.alu_cin}, 32'd1);
        wait_done0(1, "xor");

        // Signed overflow at full width
        @(negedge clk);
        start0({1'b0, {(W-1){1'b1}}}, W'(16'h0001), 3'd0, 1'b0);
        wait_done0(1, "ovf");

        // Start pulsed during RUN is ignored
        @(negedge clk);
        start0(W'(16'h003C), W'(16'h0005), 3'd0, 1'b0);
        u_if0.a = W'(16'h0011);
        u_if0.b = W'(16'h0011);
        u_if0.start = 1'b1;
        @(negedge clk);
        u_if0.start = 1'b0;
        wait_done0(2, "ign");
        @(negedge clk);
        check("ign_no_queue", {31'd0, u_if0.busy}, 32'd0);

        // Start while in DONE goes straight back to RUN
        start0(W'(16'h0FFF), W'(16'h0001), 3'd0, 1'b0);
        wait_done0(1, "wide");
        start0(W'(16'h0012), W'(16'h0034), 3'd0, 1'b1);
        check("redo_busy", {31'd0, u_if0.busy}, 32'd1);
        check("redo_done", {31'd0, u_if0.done}, 32'd0);
        wait_done0(1, "redo");

        // Asynchronous reset in the middle of RUN at k=1
        @(negedge clk);
        start0(W'(16'h003C), W'(16'h0005), 3'd0, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        if (sb0.size() != 0) void'(sb0.pop_back());
        check("arst_busy",   {31'd0, u_if0.busy}, 32'd0);
        check("arst_done",   {31'd0, u_if0.done}, 32'd0);
        check("arst_result", u_if0.result, 32'd0);
        check("arst_flags",  u_if0.flags, 32'd0);
        check("arst_en",     {31'd0, u_if0.alu_enable}, 32'd1);
        check("arst_alu_b",  u_if0.alu_b, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        start0(W'(16'h0021), W'(16'h0013), 3'd0, 1'b0);
        wait_done0(1, "post_rst");

        // DONE_HOLD=1 instance: done stays high until the next start
        @(negedge clk);
        u_if1.a = W'(16'h1234); u_if1.b = W'(16'h0055); u_if1.op = 3'd0; u_if1.cin = 1'b0;
        u_if1.start = 1'b1;
        sb1.push_back(ref_op(3'd0, W'(16'h1234), W'(16'h0055), 1'b0));
        @(posedge clk);
        @(negedge clk);
        u_if1.start = 1'b0;
        edges = 1;
        while (!u_if1.done && edges < 4 * N + 4) begin
            @(negedge clk);
            edges++;
        end
        check("hold_lat", edges, N + 1);
        if (sb1.size() != 0) exp_v = sb1.pop_front();
        else exp_v = '0;
        check("hold_res",   u_if1.result, exp_v[W-1:0]);
        check("hold_flags", u_if1.flags, exp_v[W+3:W]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_done_high", {31'd0, u_if1.done}, 32'd1);
            check("hold_res_stable", u_if1.result, exp_v[W-1:0]);
        end
        u_if1.a = W'(16'h0F0F); u_if1.b = W'(16'h00F1); u_if1.op = 3'd0; u_if1.cin = 1'b0;
        u_if1.start = 1'b1;
        sb1.push_back(ref_op(3'd0, W'(16'h0F0F), W'(16'h00F1), 1'b0));
        @(posedge clk);
        @(negedge clk);
        u_if1.start = 1'b0;
        check("hold_restart_busy", {31'd0, u_if1.busy}, 32'd1);
        check("hold_restart_done", {31'd0, u_if1.done}, 32'd0);
        edges = 1;
        while (!u_if1.done && edges < 4 * N + 4) begin
            @(negedge clk);
            edges++;
        end
        check("hold2_lat", edges, N + 1);
        if (sb1.size() != 0) exp_v = sb1.pop_front();
        else exp_v = '0;
        check("hold2_res",   u_if1.result, exp_v[W-1:0]);
        check("hold2_flags", u_if1.flags, exp_v[W+3:W]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_nibble_seq.md
ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 SHALL have parameter DONE_HOLD, default 0; 0 makes done a 1-cycle pulse, 1 holds done high until the next accepted start.
REQ-002 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports start (in, 1), op (in, 3), bank (in, 1) and cin (in, 1): request strobe, ALU operation, operation bank and initial carry.
REQ-005 SHALL have ports a and b (in, W) as operands and result (out, W); W=8, or W=16 with ALU_SEQ_WIDE_EN.
REQ-006 SHALL have ports busy (out, 1), done (out, 1) and flags (out, 4, NZVC order: [3]=N, [2]=Z, [1]=V, [0]=C).
REQ-007 SHALL have ports alu_a, alu_b (out, 4), alu_op (out, 3), alu_cin, alu_bank and alu_enable (out, 1, active low) to drive the 4-bit ALU.
REQ-008 SHALL have ports alu_result and alu_flags (in, 4) returned by the ALU in the same cycle (combinational lookup).

Function
REQ-009 SHALL implement FSM states IDLE, RUN and DONE, plus a nibble index k of 0..N-1, where N=W/4.
REQ-010 SHALL accept start only in IDLE or DONE, latching a, b, op, bank and cin, clearing k and moving to RUN on that edge.
REQ-011 SHALL ignore start while busy; no queuing and no effect on the operation in flight.
REQ-012 SHALL, in RUN, drive alu_enable=0, alu_a=a[4k+3:4k], alu_b=b[4k+3:4k], alu_op=op and alu_bank=bank.
REQ-013 SHALL drive alu_cin=cin when k=0, and alu_flags[0] of nibble k-1 (registered) when k>0; chaining applies for every op.
REQ-014 SHALL capture alu_result into result[4k+3:4k] at the end of each RUN cycle, then increment k; after k=N-1 it SHALL go to DONE.
REQ-015 SHALL set flags on exit from RUN: N, V and C from the last nibble's alu_flags; Z=1 only if every nibble's Z flag was 1.
REQ-016 SHALL take exactly N+1 cycles from the start edge to done high (8-bit: 3, 16-bit: 5); busy SHALL be high exactly during RUN.
REQ-017 SHALL hold alu_enable=1 outside RUN; alu_a, alu_b and alu_cin SHALL be 0 outside RUN.
REQ-018 SHALL hold result and flags stable from done until the next accepted start.
REQ-019 SHALL, with DONE_HOLD=0, return from DONE to IDLE after one cycle unless start is present; start in DONE SHALL go directly to RUN.
REQ-020 SHALL, with DONE_HOLD=1, remain in DONE until start.

Reset
REQ-021 SHALL, on reset_n low (including mid-operation), immediately force IDLE, k=0, result=0, flags=0, busy=0, done=0 and alu_enable=1, with all ALU-drive outputs at 0.
REQ-022 SHALL accept start on the first rising clk edge after reset_n deasserts.

Configuration
REQ-023 SHALL use macro ALU_SEQ_WIDE_EN: defined gives W=16, N=4 and 4 RUN cycles; undefined gives W=8, N=2 and 2 RUN cycles, with no other behaviour change.

Structure
REQ-024 SHALL take the FSM state encoding, the NZVC bit-index constants and the W/N width constants from shared package alu_seq_pkg.
REQ-025 SHALL be a single module with no sub-modules; the ALU is instantiated alongside it by the integrator, not inside it.

Verification
REQ-026 SHALL cover this scenario with the 8-bit build, bench ALU model with op 0 = ADD, a=0x3C, b=0x05, cin=0, op=0: result=0x41, flags C=0, Z=0, with done exactly 3 cycles after start.
REQ-027 SHALL cover this carry scenario: a=0xFF, b=0x01, ADD: nibble 1 sees alu_cin=1; result=0x00, Z=1, C=1.
REQ-028 SHALL cover this scenario: start is pulsed again during RUN with a=0x11; that pulse is ignored and the first result is unchanged.
REQ-029 SHALL cover this scenario: reset_n is pulled low during RUN at k=1; busy, done and result go to 0 and alu_enable goes to 1 asynchronously, and the next start works normally.
REQ-030 SHALL cover the ALU_SEQ_WIDE_EN build: a=0x0FFF, b=0x0001, ADD gives result=0x1000, C=0, Z=0, with done 5 cycles after start.
REQ-031 SHALL cover this scenario with DONE_HOLD=1: done stays high for 10 idle cycles, then start in DONE begins RUN on the next edge.
